// File: rtl/fp16_pkg.sv
// ---------------------------------------------------------------------------
// fp16_pkg
// Shared definitions for the half-precision arithmetic datapaths.
//   EXP_LEN / MANT_LEN / GUARD_LEN / TAG_LEN : default field widths
//   MANT_W                                   : extended mantissa width
//   fp_beat_t                                : one intermediate result beat
//   stage_state_e                            : elastic stage occupancy state
// ---------------------------------------------------------------------------
package fp16_pkg;

    localparam int EXP_LEN   = 5;
    localparam int MANT_LEN  = 10;
    localparam int GUARD_LEN = 7;
    localparam int TAG_LEN   = 4;
    localparam int MANT_W    = MANT_LEN + GUARD_LEN;

    typedef struct packed {
        logic               sign;
        logic [EXP_LEN-1:0] exp;
        logic [MANT_W-1:0]  mant;
        logic [TAG_LEN-1:0] tag;
    } fp_beat_t;

    // The encoding equals the number of entries held, so occupancy is a
    // direct read of the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/fp_pipe_stage_hs.sv
// ---------------------------------------------------------------------------
// fp_pipe_stage_hs
// Elastic valid/ready pipeline stage carrying one arithmetic intermediate
// (sign, exponent, extended mantissa, tag) per beat.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous discard of all held entries
//   in_valid / in_ready : upstream handshake
//   in_sign/exp/mant/tag: upstream beat
//   out_valid/out_ready : downstream handshake
//   out_sign/exp/mant/tag: main entry
//   occupancy           : entries held (0..2)
// SKID_EN=1 gives a two-entry skid buffer with in_ready driven purely from
// registered state; SKID_EN=0 gives a single register whose in_ready looks
// combinationally at out_ready.
// ---------------------------------------------------------------------------
module fp_pipe_stage_hs
    import fp16_pkg::*;
#(
    parameter int EXP_LEN   = fp16_pkg::EXP_LEN,
    parameter int MANT_LEN  = fp16_pkg::MANT_LEN,
    parameter int GUARD_LEN = fp16_pkg::GUARD_LEN,
    parameter int TAG_LEN   = fp16_pkg::TAG_LEN,
    parameter bit SKID_EN   = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sign,
    input  logic [EXP_LEN-1:0]            in_exp,
    input  logic [MANT_LEN+GUARD_LEN-1:0] in_mant,
    input  logic [TAG_LEN-1:0]            in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sign,
    output logic [EXP_LEN-1:0]            out_exp,
    output logic [MANT_LEN+GUARD_LEN-1:0] out_mant,
    output logic [TAG_LEN-1:0]            out_tag,
    output logic [1:0]                    occupancy
);

    // Same layout as fp_beat_t, but sized from this instance's parameters so
    // non-default widths are carried correctly.
    typedef struct packed {
        logic                          sign;
        logic [EXP_LEN-1:0]            exp;
        logic [MANT_LEN+GUARD_LEN-1:0] mant;
        logic [TAG_LEN-1:0]            tag;
    } beat_t;

    stage_state_e state_q, state_d;
    beat_t        main_q, main_d;
    beat_t        skid_q, skid_d;
    beat_t        in_beat;
    logic         in_fire;
    logic         out_fire;

    assign in_beat = '{sign: in_sign, exp: in_exp, mant: in_mant, tag: in_tag};

    // Handshake and next-state logic. Flush overrides every fire, so a beat
    // offered in the flush cycle is dropped even though in_ready may be high.
    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        out_valid = (state_q != EMPTY);
        out_fire  = out_valid & out_ready;
        if (SKID_EN) begin
            in_ready = (state_q != FULL);
        end else begin
            in_ready = ~out_valid | out_ready;
        end
        in_fire = in_valid & in_ready;

        if (flush) begin
            state_d = EMPTY;
        end else if (SKID_EN) begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_beat;
                        state_d = HALF;
                    end
                end
                HALF: begin
                    if (in_fire && out_fire) begin
                        main_d = in_beat;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new beat behind main.
                        skid_d  = in_beat;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = HALF;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end else begin
            if (in_fire) begin
                main_d  = in_beat;
                state_d = HALF;
            end else if (out_fire) begin
                state_d = EMPTY;
            end
        end
    end

    // State and storage registers; reset clears both entries at full width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_sign  = main_q.sign;
    assign out_exp   = main_q.exp;
    assign out_mant  = main_q.mant;
    assign out_tag   = main_q.tag;
    assign occupancy = state_q;

endmodule

// File: tb/tb_fp_pipe_stage_hs.sv
// Directed self-checking bench for fp_pipe_stage_hs. Instance u_skid uses the
// two-entry skid buffer, u_flat the single-register build.
module tb_fp_pipe_stage_hs;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        flush, in_valid, in_sign, out_ready;
    logic [4:0]  in_exp;
    logic [16:0] in_mant;
    logic [3:0]  in_tag;
    logic        in_ready, out_valid, out_sign;
    logic [4:0]  out_exp;
    logic [16:0] out_mant;
    logic [3:0]  out_tag;
    logic [1:0]  occupancy;

    logic        n_flush, n_in_valid, n_in_sign, n_out_ready;
    logic [4:0]  n_in_exp;
    logic [16:0] n_in_mant;
    logic [3:0]  n_in_tag;
    logic        n_in_ready, n_out_valid, n_out_sign;
    logic [4:0]  n_out_exp;
    logic [16:0] n_out_mant;
    logic [3:0]  n_out_tag;
    logic [1:0]  n_occupancy;

    int tests_run = 0;
    int fail_cnt  = 0;

    always #5 clk = ~clk;

    fp_pipe_stage_hs #(.SKID_EN(1'b1)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant), .out_tag(out_tag),
        .occupancy(occupancy)
    );

    fp_pipe_stage_hs #(.SKID_EN(1'b0)) u_flat (
        .clk(clk), .rst_n(rst_n), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_sign(n_in_sign), .in_exp(n_in_exp), .in_mant(n_in_mant), .in_tag(n_in_tag),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_sign(n_out_sign), .out_exp(n_out_exp), .out_mant(n_out_mant), .out_tag(n_out_tag),
        .occupancy(n_occupancy)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] tag);
        in_valid = v;
        in_sign  = 1'b0;
        in_exp   = 5'h0F;
        in_mant  = 17'h12340 | {13'h0, tag};
        in_tag   = tag;
    endtask

    task automatic test_reset();
        drive(1'b0, 4'h0);
        flush = 1'b0; out_ready = 1'b0;
        n_flush = 1'b0; n_in_valid = 1'b0; n_in_sign = 1'b0; n_out_ready = 1'b0;
        n_in_exp = '0; n_in_mant = '0; n_in_tag = '0;
        rst_n = 1'b0;
        #12;
        tests_run++;
        if ({out_valid, occupancy, in_ready, out_mant} !== {1'b0, 2'd0, 1'b1, 17'h0}) begin
            fail_cnt++;
            $display("[TB] FAIL reset_initial got v/occ/rdy/mant=%b/%0d/%b/%h expected 0/0/1/00000",
                     out_valid, occupancy, in_ready, out_mant);
        end
        tests_run++;
        if ({n_out_valid, n_occupancy, n_in_ready} !== {1'b0, 2'd0, 1'b1}) begin
            fail_cnt++;
            $display("[TB] FAIL reset_flat got v/occ/rdy=%b/%0d/%b expected 0/0/1",
                     n_out_valid, n_occupancy, n_in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        // Fill to FULL, then reset mid-stream.
        drive(1'b1, 4'h1); tick();
        drive(1'b1, 4'h2); tick();
        drive(1'b0, 4'h0);
        tests_run++;
        if ({occupancy, in_ready} !== {2'd2, 1'b0}) begin
            fail_cnt++;
            $display("[TB] FAIL reset_prefill got occ/rdy=%0d/%b expected 2/0", occupancy, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, occupancy, out_mant, out_tag} !== {1'b0, 2'd0, 17'h0, 4'h0}) begin
            fail_cnt++;
            $display("[TB] FAIL reset_midstream got v/occ/mant/tag=%b/%0d/%h/%h expected 0/0/00000/0",
                     out_valid, occupancy, out_mant, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10) begin
            fail_cnt++;
            $display("[TB] FAIL reset_release got rdy/v=%b/%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 4'(i));
            tick();
            tests_run++;
            if ({out_valid, occupancy, in_ready, out_sign, out_exp, out_mant, out_tag} !==
                {1'b1, 2'd1, 1'b1, 1'b0, 5'h0F, 17'h12340 | 17'(i), 4'(i)}) begin
                fail_cnt++;
                $display("[TB] FAIL stream_beat%0d got v/occ/rdy/exp/mant/tag=%b/%0d/%b/%h/%h/%h expected 1/1/1/0f/%h/%h",
                         i, out_valid, occupancy, in_ready, out_exp, out_mant, out_tag,
                         17'h12340 | 17'(i), i[3:0]);
            end
        end
        drive(1'b0, 4'h0);
        tick();
        tests_run++;
        if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
            fail_cnt++;
            $display("[TB] FAIL stream_drain got v/occ=%b/%0d expected 0/0", out_valid, occupancy);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 4'h3); tick();
        drive(1'b1, 4'h4); tick();
        drive(1'b0, 4'h0);
        tests_run++;
        if ({occupancy, in_ready, out_valid, out_tag, out_mant} !== {2'd2, 1'b0, 1'b1, 4'h3, 17'h12343}) begin
            fail_cnt++;
            $display("[TB] FAIL bp_full got occ/rdy/v/tag/mant=%0d/%b/%b/%h/%h expected 2/0/1/3/12343",
                     occupancy, in_ready, out_valid, out_tag, out_mant);
        end
        // A beat offered while FULL must be refused.
        drive(1'b1, 4'hE); tick();
        drive(1'b0, 4'h0);
        tests_run++;
        if ({occupancy, out_tag, out_mant} !== {2'd2, 4'h3, 17'h12343}) begin
            fail_cnt++;
            $display("[TB] FAIL bp_hold got occ/tag/mant=%0d/%h/%h expected 2/3/12343",
                     occupancy, out_tag, out_mant);
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if ({out_valid, out_tag, out_mant, occupancy, in_ready} !== {1'b1, 4'h4, 17'h12344, 2'd1, 1'b1}) begin
            fail_cnt++;
            $display("[TB] FAIL bp_release got v/tag/mant/occ/rdy=%b/%h/%h/%0d/%b expected 1/4/12344/1/1",
                     out_valid, out_tag, out_mant, occupancy, in_ready);
        end
        tick();
        tests_run++;
        if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
            fail_cnt++;
            $display("[TB] FAIL bp_drain got v/occ=%b/%0d expected 0/0", out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 4'h1); tick();
        drive(1'b1, 4'h2); tick();
        flush = 1'b1;
        drive(1'b1, 4'h9); tick();
        flush = 1'b0;
        drive(1'b0, 4'h0);
        tests_run++;
        if ({out_valid, occupancy, in_ready} !== {1'b0, 2'd0, 1'b1}) begin
            fail_cnt++;
            $display("[TB] FAIL flush_full got v/occ/rdy=%b/%0d/%b expected 0/0/1", out_valid, occupancy, in_ready);
        end
        // Flush while EMPTY with in_ready=1 still drops the beat.
        flush = 1'b1;
        drive(1'b1, 4'h9); tick();
        flush = 1'b0;
        drive(1'b0, 4'h0);
        out_ready = 1'b1;
        tests_run++;
        if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
            fail_cnt++;
            $display("[TB] FAIL flush_empty got v/occ/tag=%b/%0d/%h expected 0/0", out_valid, occupancy, out_tag);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            fail_cnt++;
            $display("[TB] FAIL flush_no_emerge got v/tag=%b/%h expected 0", out_valid, out_tag);
        end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        drive(1'b1, 4'h5); tick();
        out_ready = 1'b1;
        drive(1'b1, 4'h6); tick();
        drive(1'b0, 4'h0);
        tests_run++;
        if ({out_valid, out_tag, out_mant, occupancy} !== {1'b1, 4'h6, 17'h12346, 2'd1}) begin
            fail_cnt++;
            $display("[TB] FAIL simul_fire got v/tag/mant/occ=%b/%h/%h/%0d expected 1/6/12346/1",
                     out_valid, out_tag, out_mant, occupancy);
        end
        tick();
    endtask

    task automatic test_no_skid();
        n_out_ready = 1'b0;
        n_in_valid = 1'b1; n_in_exp = 5'h11; n_in_mant = 17'h00007; n_in_tag = 4'h7;
        tick();
        n_in_exp = 5'h12; n_in_mant = 17'h00008; n_in_tag = 4'h8;
        #1;
        tests_run++;
        if ({n_out_valid, n_occupancy, n_in_ready, n_out_tag} !== {1'b1, 2'd1, 1'b0, 4'h7}) begin
            fail_cnt++;
            $display("[TB] FAIL flat_stall got v/occ/rdy/tag=%b/%0d/%b/%h expected 1/1/0/7",
                     n_out_valid, n_occupancy, n_in_ready, n_out_tag);
        end
        tick();
        tests_run++;
        if ({n_out_tag, n_out_exp, n_out_mant} !== {4'h7, 5'h11, 17'h00007}) begin
            fail_cnt++;
            $display("[TB] FAIL flat_hold got tag/exp/mant=%h/%h/%h expected 7/11/00007",
                     n_out_tag, n_out_exp, n_out_mant);
        end
        n_out_ready = 1'b1;
        #1;
        tests_run++;
        if (n_in_ready !== 1'b1) begin
            fail_cnt++;
            $display("[TB] FAIL flat_ready_comb got rdy=%b expected 1", n_in_ready);
        end
        tick();
        n_in_valid = 1'b0;
        tests_run++;
        if ({n_out_valid, n_out_tag, n_out_exp, n_out_mant, n_occupancy} !== {1'b1, 4'h8, 5'h12, 17'h00008, 2'd1}) begin
            fail_cnt++;
            $display("[TB] FAIL flat_replace got v/tag/exp/mant/occ=%b/%h/%h/%h/%0d expected 1/8/12/00008/1",
                     n_out_valid, n_out_tag, n_out_exp, n_out_mant, n_occupancy);
        end
        tick();
        tests_run++;
        if ({n_out_valid, n_occupancy} !== {1'b0, 2'd0}) begin
            fail_cnt++;
            $display("[TB] FAIL flat_drain got v/occ=%b/%0d expected 0/0", n_out_valid, n_occupancy);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_simultaneous();
        test_no_skid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule

// File: doc/fp_pipe_stage_hs.md
Name: fp_pipe_stage_hs

Overview:
Parametrised elastic pipeline stage for the float arithmetic units. It carries one intermediate result per beat: sign, exponent, extended mantissa with guard/round/sticky bits, and an operation tag. Unlike a plain enable-less stage register, it adds a valid/ready handshake with backpressure, a zero-bubble skid buffer, synchronous flush and an occupancy report. It is dropped between any two arithmetic stages (align, add, normalise, round) of the adder and multiplier datapaths.

Parameters:
EXP_LEN, 5, exponent field width
MANT_LEN, 10, stored mantissa width
GUARD_LEN, 7, extra mantissa bits (hidden, carry, guard/round/sticky); mantissa field = MANT_LEN+GUARD_LEN
TAG_LEN, 4, opaque operation tag carried alongside the data
SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous discard of all held entries
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat this cycle
in_sign  in  1  sign
in_exp  in  EXP_LEN  exponent
in_mant  in  MANT_LEN+GUARD_LEN  extended mantissa
in_tag  in  TAG_LEN  tag
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_sign  out  1  sign of main entry
out_exp  out  EXP_LEN  exponent of main entry
out_mant  out  MANT_LEN+GUARD_LEN  mantissa of main entry
out_tag  out  TAG_LEN  tag of main entry
occupancy  out  2  entries held (0..2; max 1 when SKID_EN=0)

Behaviour:
- Reset (rst_n low, async): state EMPTY; out_valid=0; all data fields (both entries) cleared to zero at full width; occupancy=0; in_ready=1 once state is EMPTY.
- Fire: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Latency 1 cycle input-to-output. Throughput 1 beat/cycle when out_ready is held high.
- Outputs always present the main entry. Data is stable and unchanged while out_valid=1 and out_ready=0.
- SKID_EN=1 FSM (states EMPTY, HALF, FULL); in_ready = (state != FULL), a pure function of registered state:
  - EMPTY: in_fire -> main<=in, HALF.
  - HALF: in_fire & out_fire -> main<=in, HALF. in_fire only -> skid<=in, FULL. out_fire only -> EMPTY.
  - FULL: out_fire -> main<=skid, HALF. Otherwise hold.
- SKID_EN=0: in_ready = ~out_valid | out_ready (combinational). in_fire loads main. out_fire without in_fire -> empty.
- occupancy: EMPTY=0, HALF=1, FULL=2.
- Flush has priority over all fires. Next state is EMPTY and valids clear. A beat presented in the flush cycle is dropped even if in_ready=1. Data registers need not clear on flush.
- Reset asserted mid-operation: held beats are lost; no output glitch beyond the async clear.
- No combinational path from in_valid to out_valid. With SKID_EN=1 there is also no path from out_ready to in_ready.
- Valid never drops without a fire or flush; data/tag order is strictly preserved.

Decomposition:
- Shared package fp16_pkg:
  - EXP_LEN/MANT_LEN/GUARD_LEN constants.
  - Packed struct fp_beat_t {sign, exp, mant, tag} for main/skid storage.
  - State enum {EMPTY, HALF, FULL}.
- Single module, no sub-module. Storage is two fp_beat_t registers plus a 2-bit state.

Test Plan:
- Reset: assert rst_n=0 mid-stream with FULL state -> out_valid=0, out_mant=17'h0, occupancy=0, in_ready=1 after release.
- Streaming: out_ready=1, send sign=0, exp=5'h0F, mant=17'h1_2345, tag=1..8 on consecutive cycles -> each appears exactly 1 cycle later, 8 beats in 8 cycles, no bubbles.
- Backpressure: out_ready=0 with two beats (tag 3, tag 4) -> occupancy=2, in_ready=0 next cycle, outputs hold tag 3. Raise out_ready -> tag 3 then tag 4 in order, in_ready returns to 1.
- Flush: FULL state, assert flush with in_valid=1 tag 9 -> next cycle out_valid=0, occupancy=0; tag 9 never emerges.
- Simultaneous in/out fire in HALF: main tag 5, out_ready=1, in tag 6 -> next cycle out_tag=6, occupancy stays 1.
- SKID_EN=0 build: out_ready=0 with out_valid=1 -> in_ready=0 same cycle. out_ready=1 -> in_ready=1 same cycle, beat replaced in one cycle.
